// File: rtl/filter_output_decimator.sv
// -----------------------------------------------------------------------------
// filter_output_decimator
//
// Sits after the IIR low-pass filter of the theremin PLL chain. Every CE strobe
// delivers one filter sample; blocks of 2^DECIM_SHIFT_BITS samples are summed
// and shifted down to their average, and each average is queued in a small
// first-word-fall-through FIFO that the consumer drains with valid/ready.
//
// Optional build macro: DECIMATOR_ROUND_EN
//   defined   -> averages round half toward +infinity
//   undefined -> averages are floored (plain arithmetic shift)
//
// Ports:
//   CLK             clock, everything on the rising edge
//   RESET_N         synchronous active-low reset, clears all state
//   CE              sample strobe, IN_VALUE valid while high
//   IN_VALUE        signed filter sample (DATA_BITS)
//   OUT_VALUE       signed average at the FIFO head (OUT_BITS); last popped
//                   word when the FIFO is empty
//   OUT_VALID       FIFO not empty
//   OUT_READY       consumer accepts the head word
//   FIFO_LEVEL      number of stored words (FIFO_DEPTH_BITS+1)
//   OVERFLOW        sticky: an average was dropped because the FIFO was full
//   CLEAR_OVERFLOW  clears OVERFLOW (a simultaneous new overflow wins)
// -----------------------------------------------------------------------------
module filter_output_decimator #(
    parameter int DATA_BITS        = 30,
    parameter int DECIM_SHIFT_BITS = 4,
    parameter int OUT_BITS         = 30,
    parameter int FIFO_DEPTH_BITS  = 2
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        CE,
    input  logic signed [DATA_BITS-1:0] IN_VALUE,
    output logic signed [OUT_BITS-1:0]  OUT_VALUE,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [FIFO_DEPTH_BITS:0]    FIFO_LEVEL,
    output logic                        OVERFLOW,
    input  logic                        CLEAR_OVERFLOW
);

    localparam int ACC_BITS   = DATA_BITS + DECIM_SHIFT_BITS;
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;

    // N-1 is all ones in the counter width
    localparam logic [DECIM_SHIFT_BITS-1:0] CNT_LAST = {DECIM_SHIFT_BITS{1'b1}};
    localparam logic [DECIM_SHIFT_BITS-1:0] CNT_ONE  = DECIM_SHIFT_BITS'(1);
    localparam logic [FIFO_DEPTH_BITS-1:0]  PTR_ONE  = FIFO_DEPTH_BITS'(1);
    localparam logic [FIFO_DEPTH_BITS:0]    LEVEL_ONE  = (FIFO_DEPTH_BITS+1)'(1);
    localparam logic [FIFO_DEPTH_BITS:0]    LEVEL_FULL = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);

`ifdef DECIMATOR_ROUND_EN
    // Half an LSB of the result; the full block sum plus this still fits ACC.
    localparam logic signed [ACC_BITS-1:0] ROUND_ADD = ACC_BITS'(1) << (DECIM_SHIFT_BITS - 1);
`else
    localparam logic signed [ACC_BITS-1:0] ROUND_ADD = '0;
`endif

    // ---------------------------------------------------------------- state
    logic signed [ACC_BITS-1:0]         acc_reg;
    logic [DECIM_SHIFT_BITS-1:0]        cnt_reg;
    logic signed [DATA_BITS-1:0]        res_reg;
    logic                               push_pend_reg;

    logic [OUT_BITS-1:0]                mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]         wr_ptr_reg;
    logic [FIFO_DEPTH_BITS-1:0]         rd_ptr_reg;
    logic [FIFO_DEPTH_BITS:0]           level_reg;
    logic                               overflow_reg;
    logic signed [OUT_BITS-1:0]         out_value_reg;

    // ------------------------------------------------------- accumulator path
    logic signed [ACC_BITS-1:0]         in_ext;
    logic                               block_last;
    logic signed [ACC_BITS-1:0]         block_sum;
    logic signed [DATA_BITS-1:0]        res_next;

    assign in_ext     = {{DECIM_SHIFT_BITS{IN_VALUE[DATA_BITS-1]}}, IN_VALUE};
    assign block_last = (cnt_reg == CNT_LAST);
    // The rounding offset only enters on the closing sample of a block, so the
    // running partial sums stay exact.
    assign block_sum  = acc_reg + in_ext + (block_last ? ROUND_ADD : '0);
    // Arithmetic right shift by DECIM_SHIFT_BITS, keeping DATA_BITS: the upper
    // bits of the sum are exactly that result.
    assign res_next   = block_sum[ACC_BITS-1:DECIM_SHIFT_BITS];

    // ------------------------------------------------------------ FIFO path
    logic [OUT_BITS-1:0]                word_in;
    logic                               fifo_full;
    logic                               pop;
    logic                               push_ok;
    logic                               overflow_event;
    logic [FIFO_DEPTH_BITS-1:0]         rd_ptr_inc;

    assign word_in        = res_reg[DATA_BITS-1 -: OUT_BITS];
    assign fifo_full      = (level_reg == LEVEL_FULL);
    assign pop            = OUT_VALID && OUT_READY;
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign push_ok        = push_pend_reg && (!fifo_full || pop);
    assign overflow_event = push_pend_reg && fifo_full && !pop;
    assign rd_ptr_inc     = rd_ptr_reg + PTR_ONE;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            res_reg       <= '0;
            push_pend_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            out_value_reg <= '0;
        end else begin
            // Pushes are at least N >= 2 cycles apart, so clearing here never
            // races with the set below.
            if (push_pend_reg) begin
                push_pend_reg <= 1'b0;
            end

            if (CE) begin
                if (block_last) begin
                    res_reg       <= res_next;
                    push_pend_reg <= 1'b1;
                    acc_reg       <= '0;
                    cnt_reg       <= '0;
                end else begin
                    acc_reg <= block_sum;
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end

            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end

            if (push_ok && !pop) begin
                level_reg <= level_reg + LEVEL_ONE;
            end else if (!push_ok && pop) begin
                level_reg <= level_reg - LEVEL_ONE;
            end

            if (overflow_event) begin
                overflow_reg <= 1'b1;
            end else if (CLEAR_OVERFLOW) begin
                overflow_reg <= 1'b0;
            end

            // OUT_VALUE tracks the head word. It only moves when the head
            // changes: a pop exposes the next stored word (or the word being
            // pushed when the popped one was the last), and a push into an
            // empty FIFO exposes the new word. A pop that empties the FIFO
            // leaves the popped word visible.
            if (pop) begin
                if (level_reg > LEVEL_ONE) begin
                    out_value_reg <= mem[rd_ptr_inc];
                end else if (push_ok) begin
                    out_value_reg <= word_in;
                end
            end else if (push_ok && (level_reg == '0)) begin
                out_value_reg <= word_in;
            end
        end
    end

    // Storage array has no reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (RESET_N && push_ok) begin
            mem[wr_ptr_reg] <= word_in;
        end
    end

    assign OUT_VALUE  = out_value_reg;
    assign OUT_VALID  = (level_reg != '0);
    assign FIFO_LEVEL = level_reg;
    assign OVERFLOW   = overflow_reg;

endmodule

// File: tb/tb_filter_output_decimator.sv
// -----------------------------------------------------------------------------
// tb_filter_output_decimator
//
// Directed and random stimulus for filter_output_decimator. A queue-based
// model of the block averager and FIFO is checked against the DUT outputs on
// every falling edge; directed tests additionally compare the popped words
// against hand-computed constants. Honours DECIMATOR_ROUND_EN like the RTL.
// -----------------------------------------------------------------------------
module tb_filter_output_decimator;

    localparam int D  = 30;
    localparam int S  = 4;
    localparam int O  = 30;
    localparam int FB = 2;
    localparam int N  = 1 << S;
    localparam int DEPTH = 1 << FB;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ce = 1'b0;
    logic signed [D-1:0] in_v = '0;
    logic                ready = 1'b0;
    logic                clr = 1'b0;
    logic signed [O-1:0] out_v;
    logic                out_valid;
    logic [FB:0]         level;
    logic                ovf;

    filter_output_decimator #(
        .DATA_BITS(D), .DECIM_SHIFT_BITS(S), .OUT_BITS(O), .FIFO_DEPTH_BITS(FB)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .CE(ce), .IN_VALUE(in_v),
        .OUT_VALUE(out_v), .OUT_VALID(out_valid), .OUT_READY(ready),
        .FIFO_LEVEL(level), .OVERFLOW(ovf), .CLEAR_OVERFLOW(clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    longint blk[$];     // samples of the block in progress
    longint mq[$];      // words held in the FIFO, head first
    longint popped[$];  // words the DUT handed out (for literal checks)
    longint m_last = 0; // last popped word
    bit     m_ovf  = 1'b0;
    bit     m_pend = 1'b0;
    longint m_word = 0;

    // Average of a block: floor of sum/N, with half added first when rounding.
    function automatic longint block_avg(input longint s);
        longint r;
`ifdef DECIMATOR_ROUND_EN
        s = s + N / 2;
`endif
        r = ((s % N) + N) % N;
        return (s - r) / N;
    endfunction

    // Inputs change 1ns after the rising edge, so at the falling edge they
    // hold exactly what the next rising edge will sample. Outputs are checked
    // first (state after the previous edge), then the model is advanced.
    always @(negedge clk) begin
        longint exp_val;
        bit     m_pop;
        bit     m_full;
        longint s;

        exp_val = (mq.size() > 0) ? mq[0] : m_last;
        check("out_valid",  {63'b0, out_valid}, longint'(mq.size() > 0));
        check("fifo_level", {61'b0, level},     longint'(mq.size()));
        check("overflow",   {63'b0, ovf},       longint'(m_ovf));
        check("out_value",  out_v,              exp_val);

        if (out_valid && ready) popped.push_back(longint'(out_v));

        if (!rst_n) begin
            blk.delete();
            mq.delete();
            m_last = 0;
            m_ovf  = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_pop  = (mq.size() > 0) && ready;
            m_full = (mq.size() == DEPTH);
            if (m_pend && m_full && !m_pop) m_ovf = 1'b1;
            else if (clr)                    m_ovf = 1'b0;
            if (m_pop) m_last = mq.pop_front();
            if (m_pend && (!m_full || m_pop)) mq.push_back(m_word);
            m_pend = 1'b0;
            if (ce) begin
                blk.push_back(longint'(in_v));
                if (blk.size() == N) begin
                    s = 0;
                    foreach (blk[i]) s += blk[i];
                    m_word = block_avg(s);
                    m_pend = 1'b1;
                    blk.delete();
                end
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input longint first, input longint rest);
        for (int i = 0; i < N; i++) begin
            ce   = 1'b1;
            in_v = (i == 0) ? D'(first) : D'(rest);
            step();
        end
        ce = 1'b0;
    endtask

    task automatic check_pops(input string name, input longint exp[$]);
        check({name, "_count"}, longint'(popped.size()), longint'(exp.size()));
        for (int i = 0; i < exp.size() && i < popped.size(); i++)
            check($sformatf("%s_word%0d", name, i), popped[i], exp[i]);
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("reset_level", {61'b0, level}, 0);
        check("reset_valid", {63'b0, out_valid}, 0);
        check("reset_value", out_v, 0);

        // Constant input
        ready = 1'b1;
        popped.delete();
        send_block(1000, 1000);
        repeat (4) step();
        check_pops("const1000", '{1000});
        check("const_level", {61'b0, level}, 0);

        // Negative input and rounding
        popped.delete();
        send_block(-3, -3);
        repeat (4) step();
        check_pops("neg3", '{-3});

        popped.delete();
        send_block(8, 0);
        repeat (4) step();
`ifdef DECIMATOR_ROUND_EN
        check_pops("pos_half", '{1});
`else
        check_pops("pos_half", '{0});
`endif

        popped.delete();
        send_block(-8, 0);
        repeat (4) step();
`ifdef DECIMATOR_ROUND_EN
        check_pops("neg_half", '{0});
`else
        check_pops("neg_half", '{-1});
`endif

        // FIFO fill and overflow
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_block(k, k);
        repeat (2) step();
        check("fill_level", {61'b0, level}, 4);
        check("fill_overflow", {63'b0, ovf}, 1);
        popped.delete();
        ready = 1'b1;
        repeat (6) step();
        ready = 1'b0;
        check_pops("drain", '{1, 2, 3, 4});
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clear_overflow", {63'b0, ovf}, 0);

        // Simultaneous push and pop on a full FIFO
        popped.delete();
        for (int k = 1; k <= 4; k++) send_block(10 * k, 10 * k);
        repeat (2) step();
        check("full_level", {61'b0, level}, 4);
        send_block(50, 50);
        ready = 1'b1;          // pop on the same edge as the push
        step();
        ready = 1'b0;
        check("pushpop_level", {61'b0, level}, 4);
        check("pushpop_overflow", {63'b0, ovf}, 0);
        ready = 1'b1;
        repeat (6) step();
        check_pops("pushpop", '{10, 20, 30, 40, 50});

        // Reset mid-block
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            ce = 1'b1;
            in_v = D'(500);
            step();
        end
        ce = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_level", {61'b0, level}, 0);
        check("midrst_valid", {63'b0, out_valid}, 0);
        check("midrst_value", out_v, 0);
        send_block(200, 200);
        repeat (4) step();
        check_pops("after_reset", '{200});

        // Back-to-back random samples with random consumer stalls
        for (int i = 0; i < 10000; i++) begin
            ce    = 1'b1;
            in_v  = D'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        ce    = 1'b0;
        ready = 1'b1;
        repeat (12) step();
        check("final_level", {61'b0, level}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_output_decimator.md
# filter_output_decimator

Downstream stage of the IIR low-pass filter in the theremin sensor PLL chain. Takes the filter output on every CE strobe, averages blocks of 2^DECIM_SHIFT_BITS consecutive samples, and queues each average in a small first-word-fall-through FIFO. The consumer (CPU bus bridge or audio/pitch mapper) drains the FIFO through a valid/ready handshake at its own pace.

## Interface
- DATA_BITS, 30: width of the signed input sample, which is the filter OUT_VALUE.
- DECIM_SHIFT_BITS, 4: log2 of the decimation ratio N. Default N = 16. Legal range 1..8.
- OUT_BITS, 30: output width. Must satisfy OUT_BITS <= DATA_BITS.
- FIFO_DEPTH_BITS, 2: log2 of FIFO depth. Default 4 entries.

- CLK  in  1  clock; all logic on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- CE  in  1  input sample strobe; IN_VALUE is valid when CE=1.
- IN_VALUE  in  DATA_BITS  signed filter output sample.
- OUT_VALUE  out  OUT_BITS  signed average at the FIFO head.
- OUT_VALID  out  1  FIFO not empty.
- OUT_READY  in  1  consumer accepts the head word.
- FIFO_LEVEL  out  FIFO_DEPTH_BITS+1  number of stored words.
- OVERFLOW  out  1  sticky flag: an average was dropped because the FIFO was full.
- CLEAR_OVERFLOW  in  1  clears OVERFLOW.

## Operation
- Accumulator ACC is signed, DATA_BITS+DECIM_SHIFT_BITS wide. Sample counter CNT is DECIM_SHIFT_BITS wide.
- On a CE edge with CNT < N-1:
  - ACC <= ACC + sext(IN_VALUE)
  - CNT <= CNT+1
- On a CE edge with CNT == N-1:
  - RES <= (ACC + sext(IN_VALUE)) >>> DECIM_SHIFT_BITS (arithmetic shift; floor unless rounding is enabled)
  - PUSH_PEND <= 1
  - ACC <= 0, CNT <= 0
- RES is DATA_BITS wide and cannot overflow.
- The FIFO stores RES[DATA_BITS-1 -: OUT_BITS]; the LSBs are truncated.
- Push: on the edge after PUSH_PEND=1, RES is written and PUSH_PEND clears.
- Pop: on any edge where OUT_VALID && OUT_READY, the head advances.
- Push into a full FIFO:
  - Without a simultaneous pop, the new word is dropped, the contents are unchanged, and OVERFLOW <= 1.
  - With a simultaneous pop, both happen: level is unchanged and no overflow is flagged.
- Push and pop together on a non-full FIFO leaves the level unchanged.
- CLEAR_OVERFLOW and a new overflow event on the same edge: OVERFLOW ends at 1 (the set wins).
- OUT_VALUE is held stable while OUT_VALID=1 and no pop occurs. When empty, OUT_VALUE is the last popped word (0 after reset).
- The consumer may raise OUT_READY before OUT_VALID is high; no pop occurs while the FIFO is empty.
- CE is ignored for the handshake, which runs every cycle.

## Timing
- Reset (RESET_N=0 at an edge) has priority over CE, push, and pop, and clears all state:
  - ACC=0, CNT=0, RES=0, PUSH_PEND=0
  - FIFO empty, pointers 0
  - OUT_VALID=0, OUT_VALUE=0, FIFO_LEVEL=0, OVERFLOW=0
- Reset mid-block discards the partial sum and any pending push.
- Latency:
  - Edge E samples the N-th CE of a block.
  - RES is loaded at E and written into the FIFO at E+1.
  - With the FIFO previously empty, OUT_VALID=1 and OUT_VALUE is valid after E+1.
- Throughput: CE may be high every cycle. The minimum spacing between pushes is N cycles (N >= 2), so the single PUSH_PEND stage never collides with itself.
- FIFO_LEVEL and OVERFLOW are registered and update on the same edge as the push or pop.

## Configuration
- DECIMATOR_ROUND_EN
  - Defined: the block sum gets 2^(DECIM_SHIFT_BITS-1) added before the shift, i.e. round half toward +infinity. This cannot overflow ACC width.
  - Undefined: plain arithmetic shift, i.e. floor.
- Interface and latency are identical in both builds.

## Test plan
- Reset and constant input: defaults, 16 CEs with IN_VALUE=1000, OUT_READY=1 -> one word 1000, OUT_VALID high for one cycle, 2 edges after the 16th CE; FIFO_LEVEL returns to 0.
- Negative input and rounding:
  - 16 CEs of -3 -> -3.
  - One sample 8 and fifteen 0 -> 0 without the macro, 1 with it.
  - One sample -8 and fifteen 0 -> -1 without the macro, 0 with it.
- FIFO fill and overflow: OUT_READY=0, 5 blocks of values 1..5 -> FIFO_LEVEL=4, OVERFLOW=1. Then drain reads 1,2,3,4 in order. Pulsing CLEAR_OVERFLOW then clears the flag.
- Simultaneous push and pop when full: FIFO holds 4 words, OUT_READY=1 on the push edge -> level stays 4, OVERFLOW stays 0, new word at the tail.
- Reset mid-operation: 10 CEs of 500, then RESET_N=0 for one edge, then 16 CEs of 200 -> first output 200, all outputs 0 during reset.
- Back-to-back CE every cycle with random OUT_READY for 10000 samples of random values -> output sequence matches the reference model; no loss unless OVERFLOW=1.
